gb_flgofm_ctrl: RTL and testbench

- FIFO-style initiator for the single-port OFM flag global-buffer RAM wrapper.
- Write side: accepts flag words from the PE array over valid/ready and drives the RAM address, enable and data pins.
- Read side: returns words in order over valid/ready toward the DRAM writeback path.
- Hides the 1-cycle RAM read latency behind a 2-entry output buffer and arbitrates read against write, because the RAM shares one address.

---
 rtl/gb_flgofm_pkg.sv | 20 ++
 rtl/gb_flgofm_obuf.sv | 65 ++++++
 rtl/gb_flgofm_ctrl.sv | 116 +++++++++++
 tb/tb_gb_flgofm_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_flgofm_pkg.sv
// gb_flgofm_pkg: shared definitions for the OFM flag global-buffer controller.
//   OBUF_DEPTH - entries in the output skid buffer that hides RAM read latency
//   prio_e     - read/write arbitration priority encoding
//   cnt_width  - bits needed to hold a count in 0..depth
package gb_flgofm_pkg;

  localparam int unsigned OBUF_DEPTH = 2;

  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned OBUF_CW = cnt_width(OBUF_DEPTH);

endpackage

// File: rtl/gb_flgofm_obuf.sv
// gb_flgofm_obuf: 2-entry registered output buffer fed by RAM read data.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - synchronous flush
//   push        - capture push_data at the tail
//   push_data   - word returned by the RAM
//   pop         - consumer took the head word
//   cnt         - entries currently held
//   head        - registered head word
module gb_flgofm_obuf
  import gb_flgofm_pkg::*;
#(
  parameter int unsigned WIDTH = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [OBUF_CW-1:0] cnt,
  output logic [WIDTH-1:0]   head
);

  localparam logic [OBUF_CW-1:0] CNT_FULL = OBUF_CW'(OBUF_DEPTH);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else if (clear) begin
      cnt    <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == '0) head_q <= push_data;
          else           tail_q <= push_data;
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt    <= cnt - 1'b1;
        end
        2'b11: begin
          // simultaneous capture and pop: occupancy unchanged, data shifts
          if (cnt == CNT_FULL) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = head_q;

endmodule

// File: rtl/gb_flgofm_ctrl.sv
// gb_flgofm_ctrl: FIFO-style initiator for the single-port OFM flag RAM.
//   clk, rst_n       - clock, asynchronous active-low reset
//   clear            - synchronous flush of all state
//   wr_vld/wr_data/wr_rdy - producer side (PE array)
//   rd_vld/rd_data/rd_rdy - consumer side (DRAM writeback)
//   count/empty/full - occupancy (full refers to RAM-resident words)
//   addr_w/addr_r/write_en/read_en/data_in/data_out - RAM pins;
//                      data_out is valid the cycle after read_en
module gb_flgofm_ctrl
  import gb_flgofm_pkg::*;
#(
  parameter int unsigned SRAM_DEPTH_BIT = 6,
  parameter int unsigned SRAM_DEPTH     = 2 ** SRAM_DEPTH_BIT,
  parameter int unsigned SRAM_WIDTH     = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      wr_vld,
  input  logic [SRAM_WIDTH-1:0]     wr_data,
  output logic                      wr_rdy,
  output logic                      rd_vld,
  output logic [SRAM_WIDTH-1:0]     rd_data,
  input  logic                      rd_rdy,
  output logic [SRAM_DEPTH_BIT:0]   count,
  output logic                      empty,
  output logic                      full,
  output logic [SRAM_DEPTH_BIT-1:0] addr_w,
  output logic [SRAM_DEPTH_BIT-1:0] addr_r,
  output logic                      write_en,
  output logic                      read_en,
  output logic [SRAM_WIDTH-1:0]     data_in,
  input  logic [SRAM_WIDTH-1:0]     data_out
);

  localparam int unsigned CNT_W = SRAM_DEPTH_BIT + 1;
  localparam logic [CNT_W-1:0]   RAM_FULL  = CNT_W'(SRAM_DEPTH);
  localparam logic [OBUF_CW-1:0] OBUF_LIM  = OBUF_CW'(OBUF_DEPTH);

  logic [SRAM_DEPTH_BIT-1:0] wptr;
  logic [SRAM_DEPTH_BIT-1:0] rptr;
  logic [CNT_W-1:0]          ram_cnt;
  logic                      inflight;
  prio_e                     prio;

  logic [OBUF_CW-1:0] obuf_cnt;
  logic [OBUF_CW-1:0] occ;
  logic               room;
  logic               wreq;
  logic               rreq;
  logic               conflict;
  logic               pop;

  // obuf_cnt + inflight never exceeds OBUF_DEPTH, so OBUF_CW bits suffice
  assign occ      = obuf_cnt + OBUF_CW'(inflight);
  assign room     = (ram_cnt != RAM_FULL);
  assign wreq     = wr_vld && room;
  assign rreq     = (ram_cnt != '0) && (occ < OBUF_LIM);
  assign conflict = wreq && rreq;

  // Single RAM port: a pending read with read priority blocks the writer.
  assign wr_rdy   = room && !(rreq && (prio == PRIO_READ)) && !clear;
  assign write_en = wr_vld && wr_rdy;
  assign read_en  = rreq && (!wreq || (prio == PRIO_READ)) && !clear;
  assign data_in  = wr_data;
  assign addr_w   = wptr;
  assign addr_r   = rptr;

  assign rd_vld   = (obuf_cnt != '0) && !clear;
  assign pop      = rd_vld && rd_rdy;

  assign count    = ram_cnt + CNT_W'(inflight) + CNT_W'(obuf_cnt);
  assign empty    = (count == '0);
  assign full     = (ram_cnt == RAM_FULL);

  // Pointers wrap naturally because SRAM_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      prio     <= PRIO_WRITE;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      prio     <= PRIO_WRITE;
    end else begin
      if (write_en) wptr <= wptr + 1'b1;
      if (read_en)  rptr <= rptr + 1'b1;
      unique case ({write_en, read_en})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ;
      endcase
      inflight <= read_en;
      if (conflict) prio <= (prio == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
    end
  end

  gb_flgofm_obuf #(
    .WIDTH (SRAM_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (inflight),
    .push_data (data_out),
    .pop       (pop),
    .cnt       (obuf_cnt),
    .head      (rd_data)
  );

endmodule

// File: tb/tb_gb_flgofm_ctrl.sv
// tb_gb_flgofm_ctrl: bench for gb_flgofm_ctrl with a RAM model and a
// queue-based reference of the controller's observable behaviour.
module tb_gb_flgofm_ctrl;

  localparam int DB = 6;
  localparam int D  = 64;
  localparam int W  = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          wr_vld = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_rdy;
  logic          rd_vld;
  logic [W-1:0]  rd_data;
  logic          rd_rdy = 1'b0;
  logic [DB:0]   count;
  logic          empty;
  logic          full;
  logic [DB-1:0] addr_w;
  logic [DB-1:0] addr_r;
  logic          write_en;
  logic          read_en;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out = '0;

  always #5 clk = ~clk;

  gb_flgofm_ctrl #(
    .SRAM_DEPTH_BIT (DB),
    .SRAM_DEPTH     (D),
    .SRAM_WIDTH     (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_vld   (wr_vld),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .rd_rdy   (rd_rdy),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .addr_w   (addr_w),
    .addr_r   (addr_r),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out)
  );

  // single-port RAM with one-cycle read latency
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (write_en) mem[addr_w] <= data_in;
    if (read_en)  data_out <= mem[addr_r];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Words live in three ordered stores: RAM-resident, one in flight, output buffer.
  logic [W-1:0] m_ram[$];
  logic [W-1:0] m_ob[$];
  bit           m_infl = 1'b0;
  logic [W-1:0] m_infl_w = '0;
  bit           m_prio = 1'b0;
  int           m_wptr = 0;
  int           m_rptr = 0;

  typedef struct packed {
    logic        wreq;
    logic        rreq;
    logic        wr_rdy;
    logic        we;
    logic        re;
    logic        vld;
    logic [31:0] cnt;
  } exp_t;

  function automatic exp_t model_eval();
    exp_t e;
    int ram_n;
    int occ;
    ram_n    = m_ram.size();
    occ      = m_ob.size() + int'(m_infl);
    e.wreq   = wr_vld && (ram_n < D);
    e.rreq   = (ram_n > 0) && (occ < 2);
    e.wr_rdy = (ram_n < D) && !(e.rreq && m_prio) && !clear;
    e.we     = wr_vld && e.wr_rdy;
    e.re     = e.rreq && !clear && (!e.wreq || m_prio);
    e.vld    = (m_ob.size() > 0) && !clear;
    e.cnt    = 32'(ram_n + int'(m_infl) + m_ob.size());
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n || clear) begin
      m_ram.delete();
      m_ob.delete();
      m_infl = 1'b0;
      m_prio = 1'b0;
      m_wptr = 0;
      m_rptr = 0;
    end else begin
      e = model_eval();
      if (e.vld && rd_rdy) void'(m_ob.pop_front());
      if (m_infl) m_ob.push_back(m_infl_w);
      if (e.re) begin
        m_infl_w = m_ram.pop_front();
        m_rptr   = (m_rptr + 1) % D;
      end
      m_infl = e.re;
      if (e.we) begin
        m_ram.push_back(wr_data);
        m_wptr = (m_wptr + 1) % D;
      end
      if (e.wreq && e.rreq) m_prio = !m_prio;
    end
  end

  // monitors (only this block writes them)
  int           re_total = 0;
  logic [W-1:0] out_q[$];
  int           wrap_w = 0;
  int           wrap_r = 0;
  int           last_aw = 0;
  int           last_ar = 0;

  always @(negedge clk) begin
    exp_t e;
    e = model_eval();
    chk("wr_rdy",   wr_rdy,   e.wr_rdy);
    chk("write_en", write_en, e.we);
    chk("read_en",  read_en,  e.re);
    chk("rd_vld",   rd_vld,   e.vld);
    chk("count",    count,    e.cnt);
    chk("empty",    empty,    e.cnt == 0);
    chk("full",     full,     m_ram.size() == D);
    chk("addr_w",   addr_w,   m_wptr);
    chk("addr_r",   addr_r,   m_rptr);
    if (e.we)  chk("data_in", data_in, wr_data);
    if (e.vld) chk("rd_data", rd_data, m_ob[0]);
    if (read_en) begin
      re_total++;
      if (last_ar == D - 1 && addr_r == 0) wrap_r++;
      last_ar = addr_r;
    end
    if (write_en) begin
      if (last_aw == D - 1 && addr_w == 0) wrap_w++;
      last_aw = addr_w;
    end
    if (rd_vld && rd_rdy) out_q.push_back(rd_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    bit done;
    done    = 1'b0;
    wr_vld  = 1'b1;
    wr_data = d;
    for (int b = 0; b < 300 && !done; b++) begin
      @(negedge clk);
      done = wr_rdy;
      cyc();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no wr_rdy expected handshake for %0h", d);
    end
  endtask

  task automatic wait_empty(input int budget);
    bit done;
    done = 1'b0;
    for (int b = 0; b < budget && !done; b++) begin
      if (empty) done = 1'b1;
      else cyc();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got count %0d expected 0", count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_re;
    int base_o;
    int wcnt;
    int rcnt;
    int same;
    int bad;
    int w0;
    int r0;
    bit pw;
    bit we_s;
    bit re_s;
    bit pdone;

    // ---- reset ----
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_read_en", read_en, 0);
    chk("rst_addr_w", addr_w, 0);
    chk("rst_addr_r", addr_r, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_rdy", wr_rdy, 1);

    // ---- single word latency ----
    cyc();
    wr_vld = 1'b1; wr_data = 28'h0000001; rd_rdy = 1'b1;
    #1;
    chk("lat_we_T", write_en, 1);
    chk("lat_aw_T", addr_w, 0);
    cyc();
    wr_vld = 1'b0;
    #1;
    chk("lat_re_T1", read_en, 1);
    chk("lat_ar_T1", addr_r, 0);
    cyc(); #1;
    chk("lat_vld_T2", rd_vld, 0);
    cyc(); #1;
    chk("lat_vld_T3", rd_vld, 1);
    chk("lat_data_T3", rd_data, 28'h0000001);
    cyc(); #1;
    chk("lat_empty", empty, 1);

    // ---- fill with consumer stalled ----
    rd_rdy  = 1'b0;
    base_re = re_total;
    for (int i = 0; i < 64; i++) push_word(W'(28'h1000000 + i));
    wr_vld = 1'b0;
    #1;
    chk("fill64_count", count, 64);
    chk("fill64_full", full, 0);
    chk("fill64_reads", re_total - base_re, 2);
    push_word(28'h1000040);
    push_word(28'h1000041);
    wr_vld = 1'b0;
    #1;
    chk("fill_full", full, 1);
    chk("fill_wr_rdy", wr_rdy, 0);
    chk("fill_count", count, 66);
    wr_vld = 1'b1; wr_data = 28'h1FFFFFF;
    #1;
    chk("fill_no_we", write_en, 0);
    cyc();
    wr_vld = 1'b0;
    base_o = out_q.size();
    rd_rdy = 1'b1;
    wait_empty(400);
    chk("fill_drain_n", out_q.size() - base_o, 66);
    chk("fill_first", out_q[base_o], 28'h1000000);
    chk("fill_last", out_q[base_o + 65], 28'h1000041);

    // ---- both sides active: alternating grants ----
    wcnt = 0; rcnt = 0; same = 0; pw = 1'b0;
    wr_vld = 1'b1; wr_data = 28'h2000000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      we_s = write_en;
      re_s = read_en;
      if (c >= 10) begin
        wcnt += int'(we_s);
        rcnt += int'(re_s);
        if (c >= 11 && we_s == pw) same++;
      end
      pw = we_s;
      cyc();
      if (we_s) wr_data = wr_data + 1'b1;
    end
    wr_vld = 1'b0;
    chk("alt_writes", wcnt, 15);
    chk("alt_reads", rcnt, 15);
    chk("alt_repeat", same, 0);
    wait_empty(100);

    // ---- wrap with random back-pressure ----
    base_o = out_q.size();
    w0 = wrap_w; r0 = wrap_r;
    pdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) push_word(W'(28'h3000000 + i));
        wr_vld = 1'b0;
        pdone = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !(pdone && empty); c++) begin
          rd_rdy = 1'($urandom_range(0, 1));
          cyc();
        end
      end
    join
    rd_rdy = 1'b1;
    wait_empty(50);
    chk("wrap_n", out_q.size() - base_o, 200);
    bad = 0;
    for (int i = 0; i < 200 && base_o + i < out_q.size(); i++)
      if (out_q[base_o + i] != W'(28'h3000000 + i)) bad++;
    chk("wrap_order", bad, 0);
    chk("wrap_addr_w", (wrap_w - w0) >= 1, 1);
    chk("wrap_addr_r", (wrap_r - r0) >= 1, 1);

    // ---- back-pressure ----
    rd_rdy  = 1'b0;
    base_re = re_total;
    base_o  = out_q.size();
    for (int i = 0; i < 5; i++) push_word(W'(28'h4000000 + i));
    wr_vld = 1'b0;
    cyc();
    for (int c = 0; c < 10; c++) begin
      cyc(); #1;
      chk("bp_rd_data", rd_data, 28'h4000000);
      chk("bp_count", count, 5);
    end
    chk("bp_reads", re_total - base_re, 2);
    rd_rdy = 1'b1;
    wait_empty(50);
    chk("bp_n", out_q.size() - base_o, 5);
    for (int i = 0; i < 5; i++)
      chk("bp_order", out_q[base_o + i], W'(28'h4000000 + i));

    // ---- clear with a read in flight ----
    rd_rdy = 1'b0;
    push_word(28'h5000000);
    wr_vld = 1'b0;
    repeat (3) cyc();
    wr_vld = 1'b1; wr_data = 28'h5000001;
    #1;
    chk("clr_we", write_en, 1);
    cyc();
    wr_vld = 1'b0;
    #1;
    chk("clr_re", read_en, 1);
    cyc();
    clear = 1'b1;
    #1;
    chk("clr_wr_rdy", wr_rdy, 0);
    chk("clr_read_en", read_en, 0);
    chk("clr_write_en", write_en, 0);
    chk("clr_rd_vld", rd_vld, 0);
    cyc();
    clear = 1'b0;
    #1;
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    chk("clr_vld_after", rd_vld, 0);
    rd_rdy = 1'b1; wr_vld = 1'b1; wr_data = 28'hABCDEF0;
    #1;
    chk("clr_we2", write_en, 1);
    cyc();
    wr_vld = 1'b0;
    cyc(); cyc(); #1;
    chk("clr_vld3", rd_vld, 1);
    chk("clr_data3", rd_data, 28'hABCDEF0);
    cyc();
    wait_empty(20);

    // ---- asynchronous reset mid-operation ----
    rd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_word(W'(28'h6000000 + i));
    wr_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_rd_vld", rd_vld, 0);
    chk("mrst_read_en", read_en, 0);
    chk("mrst_addr_w", addr_w, 0);
    chk("mrst_addr_r", addr_r, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    rd_rdy = 1'b1;
    push_word(28'h7000000);
    wr_vld = 1'b0;
    wait_empty(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
